// File: rtl/decodificador_7_segmentos_pkg.sv
// Shared definitions for the 7-segment bus decoder.
// Contents:
//   - Active-low segment patterns {g,f,e,d,c,b,a} for digits 0-9 and blank.
//     The display encoder (Memoria_display) uses the same patterns.
//   - FSM state encoding for the frame collector.
//   - Anode position constants (active-low, one digit enabled).
//   - Small helpers for anode decoding and the shift-add multiply by 10.
package decodificador_7_segmentos_pkg;

  // Segment patterns on seg[6:0]; dp (seg[7]) is never part of the code.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Anode enables, active-low.
  localparam logic [3:0] AN_THOUSANDS = 4'b0111;
  localparam logic [3:0] AN_HUNDREDS  = 4'b1011;
  localparam logic [3:0] AN_TENS      = 4'b1101;
  localparam logic [3:0] AN_UNITS     = 4'b1110;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    CONVERT = 2'd1,
    PUBLISH = 2'd2
  } state_t;

  // True when exactly one anode is driven low.
  function automatic logic an_one_low(input logic [3:0] an);
    return ($countones(~an) == 1);
  endfunction

  // Digit position for a single-low anode: 3 = thousands ... 0 = units.
  function automatic logic [1:0] an_to_idx(input logic [3:0] an);
    logic [1:0] idx;
    case (an)
      AN_THOUSANDS: idx = 2'd3;
      AN_HUNDREDS:  idx = 2'd2;
      AN_TENS:      idx = 2'd1;
      default:      idx = 2'd0;
    endcase
    return idx;
  endfunction

  // acc * 10 as (acc << 3) + (acc << 1); callers keep acc <= 999.
  function automatic logic [13:0] times10(input logic [13:0] acc);
    return (acc << 3) + (acc << 1);
  endfunction

endpackage

// File: rtl/decodificador_7_segmentos_seg7_a_bcd.sv
// seg7_a_bcd: combinational decoder from an active-low 7-segment pattern
// to a BCD digit.
// Ports:
//   patron  in  7  segment pattern {g,f,e,d,c,b,a}, active-low
//   valido  out 1  pattern is a known digit (or blank)
//   digito  out 4  decoded digit, 0 when invalid; blank decodes to 0
module seg7_a_bcd
  import decodificador_7_segmentos_pkg::*;
(
  input  logic [6:0] patron,
  output logic       valido,
  output logic [3:0] digito
);

  always_comb begin
    valido = 1'b1;
    digito = '0;
    case (patron)
      SEG_0:     digito = 4'd0;
      SEG_1:     digito = 4'd1;
      SEG_2:     digito = 4'd2;
      SEG_3:     digito = 4'd3;
      SEG_4:     digito = 4'd4;
      SEG_5:     digito = 4'd5;
      SEG_6:     digito = 4'd6;
      SEG_7:     digito = 4'd7;
      SEG_8:     digito = 4'd8;
      SEG_9:     digito = 4'd9;
      // Leading blanks read as zero.
      SEG_BLANK: digito = 4'd0;
      default:   valido = 1'b0;
    endcase
  end

endmodule

// File: rtl/decodificador_7_segmentos.sv
// decodificador_7_segmentos: snoops the multiplexed anode/segment bus of a
// 4-digit 7-segment display, recovers the shown decimal value and publishes
// it in binary and BCD.
// Parameters:
//   STABLE_CYCLES   clocks an {an,seg} pair must hold before capture (>= 2)
//   TIMEOUT_CYCLES  clocks allowed to gather a full frame (>= 2)
// Ports:
//   clock      in  1   system clock
//   reset      in  1   asynchronous active-high reset
//   an         in  4   anode enables, active-low, bit3 = thousands
//   seg        in  8   segments, active-low, {dp,g,f,e,d,c,b,a}
//   valor      out 14  binary value of the last complete frame
//   bcd        out 16  BCD digits of the last frame {th,hu,te,un}
//   valido     out 1   one-cycle strobe when valor/bcd update
//   error_seg  out 1   one-cycle strobe on an undecodable stable digit
//   timeout    out 1   one-cycle strobe when a partial frame is dropped
module decodificador_7_segmentos
  import decodificador_7_segmentos_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  an,
  input  logic [7:0]  seg,
  output logic [13:0] valor,
  output logic [15:0] bcd,
  output logic        valido,
  output logic        error_seg,
  output logic        timeout
);

  localparam int unsigned SW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [SW-1:0] STAB_CAP = SW'(STABLE_CYCLES - 2);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 2);

  // ---------------------------------------------------------------------
  // Input synchronizer and previous-cycle copy
  // ---------------------------------------------------------------------
  logic [3:0] an_s1, an_s2, an_p;
  logic [7:0] seg_s1, seg_s2, seg_p;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      an_s1  <= '1;
      an_s2  <= '1;
      an_p   <= '1;
      seg_s1 <= '1;
      seg_s2 <= '1;
      seg_p  <= '1;
    end else begin
      an_s1  <= an;
      an_s2  <= an_s1;
      an_p   <= an_s2;
      seg_s1 <= seg;
      seg_s2 <= seg_s1;
      seg_p  <= seg_s2;
    end
  end

  // ---------------------------------------------------------------------
  // Stability filter
  // ---------------------------------------------------------------------
  logic          stable_ok;
  logic          capture;
  logic [SW-1:0] stab_cnt;

  assign stable_ok = ({an_s2, seg_s2} == {an_p, seg_p}) && an_one_low(an_s2);
  // Fires on the edge the count goes from STABLE_CYCLES-2 to -1; the counter
  // then saturates above that value, so a held digit captures only once.
  assign capture   = stable_ok && (stab_cnt == STAB_CAP);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stab_cnt <= '0;
    end else if (!stable_ok) begin
      stab_cnt <= '0;
    end else if (stab_cnt != STAB_MAX) begin
      stab_cnt <= stab_cnt + SW'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Segment decode
  // ---------------------------------------------------------------------
  logic       pat_ok;
  logic [3:0] pat_dig;
  logic [1:0] pos;

  seg7_a_bcd u_seg7_a_bcd (
    .patron (seg_s2[6:0]),
    .valido (pat_ok),
    .digito (pat_dig)
  );

  assign pos = an_to_idx(an_s2);

  // ---------------------------------------------------------------------
  // Frame FSM and shift-add conversion
  // ---------------------------------------------------------------------
  state_t          state_q, state_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0][3:0] dig_q, dig_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic [13:0]     acc_q, acc_d;
  logic [1:0]      idx_q, idx_d;
  logic [13:0]     valor_d;
  logic [15:0]     bcd_d;
  logic            valido_d, error_d, timeout_d;
  logic [13:0]     acc_step;

  assign acc_step = times10(acc_q) + {10'd0, dig_q[idx_q]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= COLLECT;
      mask_q    <= '0;
      dig_q     <= '0;
      to_cnt_q  <= '0;
      acc_q     <= '0;
      idx_q     <= 2'd3;
      valor     <= '0;
      bcd       <= '0;
      valido    <= 1'b0;
      error_seg <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      dig_q     <= dig_d;
      to_cnt_q  <= to_cnt_d;
      acc_q     <= acc_d;
      idx_q     <= idx_d;
      valor     <= valor_d;
      bcd       <= bcd_d;
      valido    <= valido_d;
      error_seg <= error_d;
      timeout   <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    dig_d     = dig_q;
    to_cnt_d  = to_cnt_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    valor_d   = valor;
    bcd_d     = bcd;
    valido_d  = 1'b0;
    error_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      COLLECT: begin
        if ((mask_q != 4'b0000) && (to_cnt_q == TO_LAST)) begin
          // Timeout wins: any capture on this edge is dropped with the frame.
          timeout_d = 1'b1;
          mask_d    = '0;
          to_cnt_d  = '0;
        end else begin
          if (mask_q != 4'b0000) begin
            to_cnt_d = to_cnt_q + TW'(1);
          end
          if (capture) begin
            if (pat_ok) begin
              dig_d[pos]  = pat_dig;
              mask_d[pos] = 1'b1;
            end else begin
              error_d = 1'b1;
            end
          end
          if (mask_q == 4'b1111) begin
            state_d = CONVERT;
            acc_d   = '0;
            idx_d   = 2'd3;
          end
        end
      end

      CONVERT: begin
        acc_d = acc_step;
        idx_d = idx_q - 2'd1;
        if (idx_q == 2'd0) begin
          valor_d  = acc_step;
          bcd_d    = dig_q;
          valido_d = 1'b1;
          state_d  = PUBLISH;
        end
      end

      PUBLISH: begin
        mask_d   = '0;
        to_cnt_d = '0;
        state_d  = COLLECT;
      end

      default: begin
        state_d = COLLECT;
      end
    endcase
  end

endmodule

// File: tb/tb_decodificador_7_segmentos.sv
// Bench for decodificador_7_segmentos with STABLE_CYCLES=4, TIMEOUT_CYCLES=50.
// Stimulus pushes expected valido/timeout events (value and cycle) into
// queues; a negedge monitor pops and compares whenever the DUT strobes.
// Timing reference: an {an,seg} pair driven when cyc==c is captured on edge
// c+S+2 (2 sync flops + compare register + S-1 stable counts); valido then
// shows after edge capture+5, i.e. at cyc==c+S+7.
module tb_decodificador_7_segmentos;

  localparam int unsigned S  = 4;
  localparam int unsigned TO = 50;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [13:0] valor;
  logic [15:0] bcd;
  logic        valido;
  logic        error_seg;
  logic        timeout;

  decodificador_7_segmentos #(
    .STABLE_CYCLES  (S),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .an        (an),
    .seg       (seg),
    .valor     (valor),
    .bcd       (bcd),
    .valido    (valido),
    .error_seg (error_seg),
    .timeout   (timeout)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] valor;
    logic [15:0] bcd;
    int unsigned when;
  } exp_t;

  exp_t        vq[$];
  int unsigned tq[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          err_pulses = 0;

  function automatic void check(input string nm, input logic [31:0] act,
                                input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  // Monitor
  always @(negedge clock) begin
    if (reset !== 1'b1) begin
      if (valido === 1'b1) begin
        if (vq.size() == 0) begin
          check("unexpected valido", valido, 0);
        end else begin
          exp_t e;
          e = vq.pop_front();
          check("valor", valor, e.valor);
          check("bcd", bcd, e.bcd);
          check("valido cycle", cyc, e.when);
        end
      end
      if (timeout === 1'b1) begin
        if (tq.size() == 0) begin
          check("unexpected timeout", timeout, 0);
        end else begin
          check("timeout cycle", cyc, tq.pop_front());
        end
      end
      if (error_seg === 1'b1) err_pulses++;
    end
  end

  // Stimulus helpers; each is entered and left at posedge+1.
  int unsigned t_dig;

  task automatic put(input logic [3:0] a, input logic [7:0] s,
                     input int unsigned n);
    an  = a;
    seg = s;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic show(input logic [3:0] a, input logic [7:0] s,
                      input int unsigned n);
    t_dig = cyc;
    put(a, s, n);
    put(4'b1111, 8'hFF, 1);
  endtask

  task automatic expect_frame(input logic [13:0] v, input logic [15:0] b);
    exp_t e;
    e.valor = v;
    e.bcd   = b;
    e.when  = cyc + S + 7;
    vq.push_back(e);
  endtask

  task automatic idle(input int unsigned n);
    put(4'b1111, 8'hFF, n);
  endtask

  int err_base;

  initial begin
    reset = 1'b1;
    an    = 4'b1111;
    seg   = 8'hFF;
    repeat (3) @(posedge clock);
    #1;
    check("reset valor", valor, 0);
    check("reset bcd", bcd, 0);
    check("reset valido", valido, 0);
    check("reset error_seg", error_seg, 0);
    check("reset timeout", timeout, 0);
    reset = 1'b0;
    idle(3);

    // Nominal frame 1023
    show(4'b0111, 8'hF9, 10);
    show(4'b1011, 8'hC0, 10);
    show(4'b1101, 8'hA4, 10);
    expect_frame(14'd1023, 16'h1023);
    show(4'b1110, 8'hB0, 10);
    idle(30);

    // Reset in the middle of CONVERT for frame 4321 (never published)
    show(4'b0111, 8'h99, 8);
    show(4'b1011, 8'hB0, 8);
    show(4'b1101, 8'hA4, 8);
    show(4'b1110, 8'hF9, 8);   // returns at cyc = c+9, inside CONVERT
    reset = 1'b1;
    #1;
    check("midconv valor", valor, 0);
    check("midconv bcd", bcd, 0);
    check("midconv valido", valido, 0);
    check("midconv error_seg", error_seg, 0);
    check("midconv timeout", timeout, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle(30);
    check("post-reset valor", valor, 0);

    // Glitch rejection: 3-cycle units hold ignored, 4-cycle hold accepted
    show(4'b0111, 8'hF9, 8);
    show(4'b1011, 8'hF9, 8);
    show(4'b1101, 8'hF9, 8);
    show(4'b1110, 8'h92, 3);
    expect_frame(14'd1115, 16'h1115);
    show(4'b1110, 8'h92, 4);
    idle(30);

    // Blank (7F via FF) and an undecodable tens pattern 8C
    err_base = err_pulses;
    show(4'b0111, 8'hFF, 8);
    show(4'b1011, 8'hC0, 8);
    show(4'b1101, 8'h8C, 8);
    show(4'b1110, 8'h92, 8);
    check("error_seg pulses", err_pulses - err_base, 1);
    expect_frame(14'd25, 16'h0025);
    show(4'b1101, 8'hA4, 8);
    idle(30);
    check("error_seg pulses total", err_pulses - err_base, 1);

    // Timeout: units and tens only; pulse 49 edges after first capture
    tq.push_back(cyc + S + 2 + TO - 1);
    show(4'b1110, 8'h92, 8);
    show(4'b1101, 8'hA4, 8);
    idle(70);
    check("timeout keeps valor", valor, 25);
    check("timeout keeps bcd", bcd, 16'h0025);

    // 9999 with units overwritten to 8 (0x80 = dp + pattern 00) before completion
    show(4'b1110, 8'h90, 8);
    show(4'b0111, 8'h90, 8);
    show(4'b1011, 8'h90, 8);
    show(4'b1110, 8'h80, 8);
    expect_frame(14'd9998, 16'h9998);
    show(4'b1101, 8'h90, 8);
    idle(30);

    check("pending valido events", vq.size(), 0);
    check("pending timeout events", tq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
